// File: rtl/product_accumulator.sv
// product_accumulator: sums COUNT consecutive products (one per i_accept strobe)
// into a dot-product result presented on a valid/ready handshake. The input is
// never stalled; a completed result that finds the previous one still unconsumed
// overwrites it and raises the sticky o_overrun flag.
// Build option: define PRODUCT_ACCUMULATOR_SIGNED_EN to treat i_c as two's
// complement (sign-extended); otherwise i_c is unsigned (zero-extended).
module product_accumulator #(
    parameter int DATA_WIDTH_C = 16,
    parameter int COUNT        = 4,
    parameter int CNT_WIDTH    = 8,
    parameter int SUM_WIDTH    = DATA_WIDTH_C + CNT_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_nrst,
    input  logic [DATA_WIDTH_C-1:0] i_c,
    input  logic                    i_accept,
    input  logic                    i_clr,
    output logic [SUM_WIDTH-1:0]    o_sum,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [CNT_WIDTH-1:0]    o_count,
    output logic                    o_overrun
);

    // Counter value at which the next strobe closes the group.
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(COUNT - 1);

    logic [SUM_WIDTH-1:0] acc;
    logic [SUM_WIDTH-1:0] sum_next;
    logic                 complete;
    logic                 transfer;

    // Widen a product word to accumulator width.
    function automatic logic [SUM_WIDTH-1:0] extend(input logic [DATA_WIDTH_C-1:0] c);
`ifdef PRODUCT_ACCUMULATOR_SIGNED_EN
        logic signed [DATA_WIDTH_C-1:0] cs;
        cs = $signed(c);
        return SUM_WIDTH'(cs);
`else
        return SUM_WIDTH'(c);
`endif
    endfunction

    // Running sum including the current product, and handshake/completion qualifiers.
    always_comb begin
        sum_next = acc + extend(i_c);
        complete = i_accept && (o_count == LAST);
        transfer = o_valid && i_ready;
    end

    // Accumulator, product counter, result register and handshake flags.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            acc       <= '0;
            o_count   <= '0;
            o_sum     <= '0;
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
        end else if (i_clr) begin
            // A strobe coinciding with clear is dropped; o_sum keeps its value.
            acc       <= '0;
            o_count   <= '0;
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            if (complete) begin
                o_sum   <= sum_next;
                acc     <= '0;
                o_count <= '0;
                o_valid <= 1'b1;
                // Overwriting a result the consumer has not taken this cycle.
                if (o_valid && !i_ready) begin
                    o_overrun <= 1'b1;
                end
            end else begin
                if (i_accept) begin
                    acc     <= sum_next;
                    o_count <= o_count + CNT_WIDTH'(1);
                end
                if (transfer) begin
                    o_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Testbench for product_accumulator (default parameters, COUNT=4).
// Table-driven vectors for the basic and gapped-group cases, hand sequences for
// stall/overrun, simultaneous transfer+completion, clear, reset and sign handling.
// Every completed group's expected sum is queued when its final strobe is driven
// and compared when the consumer side takes the result.
module tb_product_accumulator;

    localparam int DW    = 16;
    localparam int COUNT = 4;
    localparam int CW    = 8;
    localparam int SW    = DW + CW;

    logic          clk;
    logic          nrst;
    logic [DW-1:0] c;
    logic          accept;
    logic          clr;
    logic [SW-1:0] sum;
    logic          valid;
    logic          ready;
    logic [CW-1:0] count;
    logic          overrun;

    int total = 0;
    int bad   = 0;

    logic [SW-1:0] sb_q[$];
    logic [SW-1:0] m_acc;
    int            m_n;

    typedef struct {
        logic          acc;
        logic [DW-1:0] c;
        logic          rdy;
        logic [CW-1:0] cnt;
        logic          vld;
        logic          ovr;
        logic [SW-1:0] sum;
    } vec_t;

    vec_t tbl[$];

    product_accumulator #(
        .DATA_WIDTH_C(DW),
        .COUNT(COUNT),
        .CNT_WIDTH(CW),
        .SUM_WIDTH(SW)
    ) dut (
        .i_clk    (clk),
        .i_nrst   (nrst),
        .i_c      (c),
        .i_accept (accept),
        .i_clr    (clr),
        .o_sum    (sum),
        .o_valid  (valid),
        .i_ready  (ready),
        .o_count  (count),
        .o_overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [SW-1:0] ext(input logic [DW-1:0] v);
`ifdef PRODUCT_ACCUMULATOR_SIGNED_EN
        return {{CW{v[DW-1]}}, v};
`else
        return {{CW{1'b0}}, v};
`endif
    endfunction

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string name, input logic [CW-1:0] ecnt, input logic evld,
                               input logic eovr, input logic [SW-1:0] esum);
        check({name, ".count"},   SW'(count),   SW'(ecnt));
        check({name, ".valid"},   SW'(valid),   SW'(evld));
        check({name, ".overrun"}, SW'(overrun), SW'(eovr));
        check({name, ".sum"},     sum,          esum);
    endtask

    // Drive one cycle of stimulus, update the reference sum, step past the edge.
    task automatic drive(input logic a, input logic [DW-1:0] v, input logic cl, input logic r);
        accept = a;
        c      = v;
        clr    = cl;
        ready  = r;
        if (cl) begin
            m_acc = '0;
            m_n   = 0;
        end else if (a) begin
            m_acc = m_acc + ext(v);
            m_n++;
            if (m_n == COUNT) begin
                sb_q.push_back(m_acc);
                m_acc = '0;
                m_n   = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Consumer side: a result is taken on the edge where valid && ready.
    always @(negedge clk) begin
        if (nrst && valid && ready) begin
            if (sb_q.size() == 0) begin
                check("sb.unexpected_result", sum, '1);
            end else begin
                check("sb.result", sum, sb_q.pop_front());
            end
        end
    end

    initial begin
        nrst   = 1'b0;
        c      = '0;
        accept = 1'b0;
        clr    = 1'b0;
        ready  = 1'b0;
        m_acc  = '0;
        m_n    = 0;

        // Basic group 3,5,7,9 with the consumer always ready.
        tbl.push_back('{1'b1, 16'd3, 1'b1, 8'd1, 1'b0, 1'b0, 24'd0});
        tbl.push_back('{1'b1, 16'd5, 1'b1, 8'd2, 1'b0, 1'b0, 24'd0});
        tbl.push_back('{1'b1, 16'd7, 1'b1, 8'd3, 1'b0, 1'b0, 24'd0});
        tbl.push_back('{1'b1, 16'd9, 1'b1, 8'd0, 1'b1, 1'b0, 24'd24});
        tbl.push_back('{1'b0, 16'd0, 1'b1, 8'd0, 1'b0, 1'b0, 24'd24});
        // Two groups of 0xFFFF with idle cycles between strobes.
        for (int g = 0; g < 2; g++) begin
            for (int k = 1; k <= COUNT; k++) begin
                tbl.push_back('{1'b1, 16'hFFFF, 1'b1, CW'(k % COUNT), (k == COUNT), 1'b0,
                                (g == 0 && k < COUNT) ? 24'd24 : 24'h3FFFC});
                tbl.push_back('{1'b0, 16'h0000, 1'b1, CW'(k % COUNT), 1'b0, 1'b0,
                                (g == 0 && k < COUNT) ? 24'd24 : 24'h3FFFC});
            end
        end

        // Reset state.
        @(posedge clk);
        #1;
        check_state("reset", 8'd0, 1'b0, 1'b0, 24'd0);
        nrst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].acc, tbl[i].c, 1'b0, tbl[i].rdy);
            check_state($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].vld, tbl[i].ovr, tbl[i].sum);
        end

        // Stall: group A = 4 held, group B = 8 overwrites it.
        for (int k = 0; k < COUNT; k++) drive(1'b1, 16'd1, 1'b0, 1'b0);
        check_state("stall.a", 8'd0, 1'b1, 1'b0, 24'd4);
        for (int k = 0; k < COUNT; k++) drive(1'b1, 16'd2, 1'b0, 1'b0);
        check_state("stall.b", 8'd0, 1'b1, 1'b1, 24'd8);
        void'(sb_q.pop_front());
        drive(1'b0, 16'd0, 1'b0, 1'b1);
        check_state("stall.drain", 8'd0, 1'b0, 1'b1, 24'd8);
        drive(1'b0, 16'd0, 1'b0, 1'b0);
        check_state("stall.hold", 8'd0, 1'b0, 1'b1, 24'd8);

        // Clear overrun, then transfer and completion on the same edge.
        drive(1'b0, 16'd0, 1'b1, 1'b0);
        check_state("clr.ovr", 8'd0, 1'b0, 1'b0, 24'd8);
        for (int k = 0; k < COUNT; k++) drive(1'b1, 16'd1, 1'b0, 1'b0);
        check_state("simul.a", 8'd0, 1'b1, 1'b0, 24'd4);
        drive(1'b1, 16'd1, 1'b0, 1'b0);
        drive(1'b1, 16'd2, 1'b0, 1'b0);
        drive(1'b1, 16'd3, 1'b0, 1'b0);
        drive(1'b1, 16'd4, 1'b0, 1'b1);
        drive(1'b0, 16'd0, 1'b0, 1'b0);
        check_state("simul.b", 8'd0, 1'b1, 1'b0, 24'd10);
        drive(1'b0, 16'd0, 1'b0, 1'b1);
        check_state("simul.drain", 8'd0, 1'b0, 1'b0, 24'd10);

        // Clear with a coincident strobe drops the partial sum and the strobe.
        drive(1'b1, 16'd1, 1'b0, 1'b1);
        drive(1'b1, 16'd1, 1'b0, 1'b1);
        check_state("clr.pre", 8'd2, 1'b0, 1'b0, 24'd10);
        drive(1'b1, 16'd1, 1'b1, 1'b1);
        check_state("clr.post", 8'd0, 1'b0, 1'b0, 24'd10);
        for (int k = 0; k < COUNT; k++) drive(1'b1, 16'd1, 1'b0, 1'b1);
        check_state("clr.group", 8'd0, 1'b1, 1'b0, 24'd4);
        drive(1'b0, 16'd0, 1'b0, 1'b1);

        // Asynchronous reset mid-group clears everything immediately.
        drive(1'b1, 16'd5, 1'b0, 1'b1);
        drive(1'b1, 16'd5, 1'b0, 1'b1);
        check_state("rst.pre", 8'd2, 1'b0, 1'b0, 24'd4);
        nrst = 1'b0;
        #2;
        check_state("rst.async", 8'd0, 1'b0, 1'b0, 24'd0);
        m_acc = '0;
        m_n   = 0;
        @(posedge clk);
        #1;
        nrst = 1'b1;
        for (int k = 0; k < COUNT; k++) drive(1'b1, 16'd1, 1'b0, 1'b1);
        check_state("rst.group", 8'd0, 1'b1, 1'b0, 24'd4);
        drive(1'b0, 16'd0, 1'b0, 1'b1);

        // Sign handling: 0xFFFF, 0xFFFF, 2, 0.
        drive(1'b1, 16'hFFFF, 1'b0, 1'b0);
        drive(1'b1, 16'hFFFF, 1'b0, 1'b0);
        drive(1'b1, 16'd2,    1'b0, 1'b0);
        drive(1'b1, 16'd0,    1'b0, 1'b0);
`ifdef PRODUCT_ACCUMULATOR_SIGNED_EN
        check_state("sign", 8'd0, 1'b1, 1'b0, 24'd0);
`else
        check_state("sign", 8'd0, 1'b1, 1'b0, 24'h20000);
`endif
        drive(1'b0, 16'd0, 1'b0, 1'b1);
        drive(1'b0, 16'd0, 1'b0, 1'b0);

        check("sb.leftover", SW'(sb_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
